// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the SDRAM request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int C_DEF_DATA_W = 16;
    localparam int C_DEF_ADDR_W = 24;
    localparam int C_LEN_W      = 9;

    localparam logic [9:0] C_TIMEOUT_LIMIT = 10'd1023;

    typedef logic [C_LEN_W-1:0] len_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wr_fifo
// Description : Synchronous show-ahead FIFO with occupancy output and a
//               checkpointed read pointer that can be rewound.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wr_fifo #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    input  logic              i_hold,
    input  logic              i_rewind,
    output logic              o_full,
    output logic [FIFO_AW:0]  o_level,
    output logic [DATA_W-1:0] o_head
);

    localparam int c_DEPTH = 2**FIFO_AW;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [FIFO_AW:0]  r_wr_ptr;
    logic [FIFO_AW:0]  r_rd_ptr;
    logic [FIFO_AW:0]  r_cmt_ptr;
    logic [FIFO_AW:0]  w_rd_nxt;
    logic              w_pop_ok;
    logic              w_push_ok;

    // While i_hold is high, popped words stay reserved so a rewind can restore them
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (r_wr_ptr - r_cmt_ptr) == (FIFO_AW+1)'(c_DEPTH);
    assign w_pop_ok  = i_pop && (o_level != '0);
    assign w_push_ok = i_push && (!o_full || (w_pop_ok && !i_hold));
    assign w_rd_nxt  = i_rewind ? r_cmt_ptr : r_rd_ptr + (FIFO_AW+1)'(w_pop_ok);
    assign o_head    = (o_level == '0) ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cmt_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            if (!i_hold) begin
                r_cmt_ptr <= w_rd_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_req_arbiter
// Description : Buffers streaming writes into aligned bursts and arbitrates
//               them with single read commands onto the sdram_top request port.
//               Optional watchdog: define SDRAM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int ADDR_W    = C_DEF_ADDR_W,
    parameter int FIFO_AW   = 5,
    parameter int BURST_LEN = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              wr_push,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_full,
    output logic [FIFO_AW:0]  wr_level,
    input  logic              wr_base_load,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic              wr_flush,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [8:0]        rd_len,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_dout,
    output logic              rd_valid,
    output logic              rd_done,
    input  logic              sdram_init_done,
    input  logic              sdram_busy,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [8:0]        sdwr_bytes,
    output logic [DATA_W-1:0] sdram_wr_data,
    input  logic              sdram_wr_ack,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [8:0]        sdrd_bytes,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sdram_rd_data
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    output logic              err_timeout
`endif
);

    localparam int               c_BW        = $clog2(BURST_LEN);
    localparam logic [FIFO_AW:0] c_BURST     = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] c_NEAR_FULL = (FIFO_AW+1)'(2**FIFO_AW - BURST_LEN);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_ptr_loaded;
    logic              r_flush_pend;
    logic              r_rd_pend;
    len_t              r_wr_cnt;
    len_t              r_rd_cnt;
    len_t              w_wr_cnt_nxt;
    len_t              w_rd_cnt_nxt;
    logic [FIFO_AW:0]  w_blen;
    logic [FIFO_AW:0]  w_wr_len;
    logic              w_go;
    logic              w_near_full;
    logic              w_wr_go;
    logic              w_rd_go;
    logic              w_in_wr;
    logic              w_pop;
    logic              w_hold;
    logic              w_rewind;

    assign w_in_wr      = (r_state == S_WR_REQ) || (r_state == S_WR_DATA);
    assign w_pop        = w_in_wr && sdram_wr_ack;
    assign w_wr_cnt_nxt = r_wr_cnt + len_t'(1);
    assign w_rd_cnt_nxt = r_rd_cnt + len_t'(1);

    // Burst length that stops exactly at the next BURST_LEN-aligned address
    assign w_blen      = c_BURST - (FIFO_AW+1)'(r_wr_ptr[c_BW-1:0]);
    assign w_wr_len    = (wr_level < w_blen) ? wr_level : w_blen;
    assign w_go        = sdram_init_done && !sdram_busy;
    assign w_near_full = wr_level >= c_NEAR_FULL;
    assign w_rd_go     = w_go && !w_near_full && r_rd_pend;
    assign w_wr_go     = w_go && (w_near_full || (!r_rd_pend &&
                         ((wr_level >= w_blen) || (r_flush_pend && wr_level != '0))));

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [9:0] r_wdog;
    logic       w_ack;
    logic       w_abort;

    assign w_ack    = w_in_wr ? sdram_wr_ack : sdram_rd_ack;
    assign w_abort  = (r_state != S_IDLE) && (r_wdog == C_TIMEOUT_LIMIT) && !w_ack;
    assign w_hold   = w_in_wr;
    assign w_rewind = w_abort && w_in_wr;

    always_ff @(posedge clk_50m) begin
        if (rst || r_state == S_IDLE || w_ack || w_abort) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 10'd1;
        end
    end
`else
    assign w_hold   = 1'b0;
    assign w_rewind = 1'b0;
`endif

    sdram_wr_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_wr_fifo (
        .clk      (clk_50m),
        .rst      (rst),
        .i_push   (wr_push),
        .i_din    (wr_din),
        .i_pop    (w_pop),
        .i_hold   (w_hold),
        .i_rewind (w_rewind),
        .o_full   (wr_full),
        .o_level  (wr_level),
        .o_head   (sdram_wr_data)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_ptr_loaded  <= 1'b0;
            r_flush_pend  <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            rd_ready      <= 1'b1;
            rd_dout       <= '0;
            rd_valid      <= 1'b0;
            rd_done       <= 1'b0;
            sdram_wr_req  <= 1'b0;
            sdram_wr_addr <= '0;
            sdwr_bytes    <= '0;
            sdram_rd_req  <= 1'b0;
            sdram_rd_addr <= '0;
            sdrd_bytes    <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            if (rd_done) begin
                rd_ready <= 1'b1;
            end
            if (rd_req && rd_ready && rd_len != '0) begin
                sdram_rd_addr <= rd_addr;
                sdrd_bytes    <= rd_len;
                r_rd_pend     <= 1'b1;
                rd_ready      <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (wr_level == '0) begin
                        r_flush_pend <= 1'b0;
                    end
                    if (w_wr_go) begin
                        sdram_wr_addr <= r_wr_ptr;
                        sdwr_bytes    <= len_t'(w_wr_len);
                        sdram_wr_req  <= 1'b1;
                        r_wr_cnt      <= '0;
                        r_ptr_loaded  <= 1'b0;
                        r_state       <= S_WR_REQ;
                    end else if (w_rd_go) begin
                        sdram_rd_req <= 1'b1;
                        r_rd_cnt     <= '0;
                        r_state      <= S_RD_REQ;
                    end
                end
                S_WR_REQ, S_WR_DATA: begin
                    if (sdram_wr_ack) begin
                        sdram_wr_req <= 1'b0;
                        r_wr_cnt     <= w_wr_cnt_nxt;
                        r_state      <= S_WR_DATA;
                        if (w_wr_cnt_nxt == sdwr_bytes) begin
                            r_state <= S_IDLE;
                            // A base reload during the burst replaces the advance
                            if (!r_ptr_loaded) begin
                                r_wr_ptr <= r_wr_ptr + ADDR_W'(sdwr_bytes);
                            end
                        end
                    end
                end
                S_RD_REQ, S_RD_DATA: begin
                    if (sdram_rd_ack) begin
                        sdram_rd_req <= 1'b0;
                        rd_dout      <= sdram_rd_data;
                        rd_valid     <= 1'b1;
                        r_rd_cnt     <= w_rd_cnt_nxt;
                        r_state      <= S_RD_DATA;
                        if (w_rd_cnt_nxt == sdrd_bytes) begin
                            rd_done   <= 1'b1;
                            r_rd_pend <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (wr_flush) begin
                r_flush_pend <= 1'b1;
            end
            if (wr_base_load) begin
                r_wr_ptr     <= wr_base;
                r_ptr_loaded <= 1'b1;
            end

`ifdef SDRAM_ARB_TIMEOUT_EN
            err_timeout <= w_abort;
            if (w_abort) begin
                r_state      <= S_IDLE;
                sdram_wr_req <= 1'b0;
                sdram_rd_req <= 1'b0;
                if (!w_in_wr) begin
                    r_rd_pend <= 1'b0;
                    rd_done   <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_req_arbiter
// Description : Directed self-checking bench for sdram_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_req_arbiter;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1;
    logic        wr_push = 1'b0;
    logic [15:0] wr_din = '0;
    logic        wr_full;
    logic [5:0]  wr_level;
    logic        wr_base_load = 1'b0;
    logic [23:0] wr_base = '0;
    logic        wr_flush = 1'b0;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = '0;
    logic [8:0]  rd_len = '0;
    logic        rd_ready;
    logic [15:0] rd_dout;
    logic        rd_valid;
    logic        rd_done;
    logic        sdram_init_done = 1'b0;
    logic        sdram_busy = 1'b0;
    logic        sdram_wr_req;
    logic [23:0] sdram_wr_addr;
    logic [8:0]  sdwr_bytes;
    logic [15:0] sdram_wr_data;
    logic        sdram_wr_ack = 1'b0;
    logic        sdram_rd_req;
    logic [23:0] sdram_rd_addr;
    logic [8:0]  sdrd_bytes;
    logic        sdram_rd_ack = 1'b0;
    logic [15:0] sdram_rd_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk_50m = ~clk_50m;

    sdram_req_arbiter dut (
        .clk_50m         (clk_50m),
        .rst             (rst),
        .wr_push         (wr_push),
        .wr_din          (wr_din),
        .wr_full         (wr_full),
        .wr_level        (wr_level),
        .wr_base_load    (wr_base_load),
        .wr_base         (wr_base),
        .wr_flush        (wr_flush),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_len          (rd_len),
        .rd_ready        (rd_ready),
        .rd_dout         (rd_dout),
        .rd_valid        (rd_valid),
        .rd_done         (rd_done),
        .sdram_init_done (sdram_init_done),
        .sdram_busy      (sdram_busy),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdwr_bytes      (sdwr_bytes),
        .sdram_wr_data   (sdram_wr_data),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdrd_bytes      (sdrd_bytes),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_data   (sdram_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic push_words(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_push = 1'b1;
            wr_din  = first + 16'(i);
            tick();
        end
        wr_push = 1'b0;
    endtask

    task automatic ack_words(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            check("wr_data", 32'(sdram_wr_data), 32'(first + 16'(i)));
            sdram_wr_ack = 1'b1;
            tick();
        end
        sdram_wr_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_wr_req", 32'(sdram_wr_req), 32'd0);
        check("rst_rd_req", 32'(sdram_rd_req), 32'd0);
        check("rst_level", 32'(wr_level), 32'd0);
        check("rst_full", 32'(wr_full), 32'd0);
        check("rst_wr_data", 32'(sdram_wr_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        sdram_init_done = 1'b1;

        // 1: aligned full burst at 0x100
        wr_base = 24'h000100;
        wr_base_load = 1'b1;
        tick();
        wr_base_load = 1'b0;
        push_words(16'h1000, 8);
        check("t1_level", 32'(wr_level), 32'd8);
        check("t1_req_early", 32'(sdram_wr_req), 32'd0);
        tick();
        check("t1_req", 32'(sdram_wr_req), 32'd1);
        check("t1_addr", 32'(sdram_wr_addr), 32'h000100);
        check("t1_bytes", 32'(sdwr_bytes), 32'd8);
        ack_words(16'h1000, 1);
        check("t1_req_drop", 32'(sdram_wr_req), 32'd0);
        ack_words(16'h1001, 7);
        check("t1_level_end", 32'(wr_level), 32'd0);
        push_words(16'h1100, 8);
        tick();
        check("t1_next_addr", 32'(sdram_wr_addr), 32'h000108);
        check("t1_next_req", 32'(sdram_wr_req), 32'd1);
        ack_words(16'h1100, 8);

        // 2: boundary-limited burst then flush residual
        wr_base = 24'h000006;
        wr_base_load = 1'b1;
        tick();
        wr_base_load = 1'b0;
        push_words(16'h2000, 5);
        check("t2_req", 32'(sdram_wr_req), 32'd1);
        check("t2_addr", 32'(sdram_wr_addr), 32'h000006);
        check("t2_bytes", 32'(sdwr_bytes), 32'd2);
        ack_words(16'h2000, 2);
        tick();
        tick();
        check("t2_idle_req", 32'(sdram_wr_req), 32'd0);
        check("t2_residual", 32'(wr_level), 32'd3);
        wr_flush = 1'b1;
        tick();
        wr_flush = 1'b0;
        tick();
        check("t2_flush_req", 32'(sdram_wr_req), 32'd1);
        check("t2_flush_addr", 32'(sdram_wr_addr), 32'h000008);
        check("t2_flush_bytes", 32'(sdwr_bytes), 32'd3);
        ack_words(16'h2002, 3);
        check("t2_flush_level", 32'(wr_level), 32'd0);
        tick();

        // 3: read wins over a small buffered write; len 0 ignored first
        push_words(16'h3000, 3);
        rd_req = 1'b1;
        rd_len = 9'd0;
        tick();
        rd_req = 1'b0;
        check("t3_len0_ready", 32'(rd_ready), 32'd1);
        tick();
        check("t3_len0_noreq", 32'(sdram_rd_req), 32'd0);
        rd_req  = 1'b1;
        rd_addr = 24'h000100;
        rd_len  = 9'd8;
        tick();
        rd_req = 1'b0;
        check("t3_ready_low", 32'(rd_ready), 32'd0);
        tick();
        check("t3_rd_req", 32'(sdram_rd_req), 32'd1);
        check("t3_wr_req", 32'(sdram_wr_req), 32'd0);
        check("t3_rd_addr", 32'(sdram_rd_addr), 32'h000100);
        check("t3_rd_bytes", 32'(sdrd_bytes), 32'd8);
        for (int i = 0; i < 8; i++) begin
            sdram_rd_ack  = 1'b1;
            sdram_rd_data = 16'h5500 + 16'(i);
            tick();
            check("t3_valid", 32'(rd_valid), 32'd1);
            check("t3_dout", 32'(rd_dout), 32'h5500 + 32'(i));
            check("t3_done", 32'(rd_done), (i == 7) ? 32'd1 : 32'd0);
        end
        sdram_rd_ack = 1'b0;
        check("t3_rd_req_drop", 32'(sdram_rd_req), 32'd0);
        check("t3_ready_hold", 32'(rd_ready), 32'd0);
        tick();
        check("t3_ready_back", 32'(rd_ready), 32'd1);
        check("t3_valid_end", 32'(rd_valid), 32'd0);
        check("t3_done_end", 32'(rd_done), 32'd0);

        // 4: near-full write beats a pending read
        sdram_busy = 1'b1;
        push_words(16'h4000, 21);
        check("t4_level", 32'(wr_level), 32'd24);
        rd_req  = 1'b1;
        rd_addr = 24'h000200;
        rd_len  = 9'd1;
        tick();
        rd_req = 1'b0;
        sdram_busy = 1'b0;
        tick();
        check("t4_wr_first", 32'(sdram_wr_req), 32'd1);
        check("t4_rd_wait", 32'(sdram_rd_req), 32'd0);
        check("t4_addr", 32'(sdram_wr_addr), 32'h00000B);
        check("t4_bytes", 32'(sdwr_bytes), 32'd5);
        ack_words(16'h3000, 3);
        ack_words(16'h4000, 2);
        check("t4_level_after", 32'(wr_level), 32'd19);
        tick();
        check("t4_rd_next", 32'(sdram_rd_req), 32'd1);
        check("t4_rd_addr", 32'(sdram_rd_addr), 32'h000200);
        sdram_rd_ack  = 1'b1;
        sdram_rd_data = 16'hBEEF;
        tick();
        sdram_rd_ack = 1'b0;
        check("t4_rd_done", 32'(rd_done), 32'd1);
        check("t4_rd_dout", 32'(rd_dout), 32'hBEEF);

        // 4b: overflow with no acks, then 5: gating by init/busy
        sdram_busy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_words(16'h6000, 32);
        check("t4_full", 32'(wr_full), 32'd1);
        check("t4_level32", 32'(wr_level), 32'd32);
        push_words(16'h6FFF, 1);
        check("t4_drop_level", 32'(wr_level), 32'd32);
        check("t4_head", 32'(sdram_wr_data), 32'h6000);
        check("t5_busy_noreq", 32'(sdram_wr_req), 32'd0);
        sdram_init_done = 1'b0;
        sdram_busy = 1'b0;
        tick();
        tick();
        check("t5_init_noreq", 32'(sdram_wr_req), 32'd0);
        sdram_init_done = 1'b1;
        tick();
        check("t5_req", 32'(sdram_wr_req), 32'd1);
        check("t5_addr", 32'(sdram_wr_addr), 32'h000000);
        check("t5_bytes", 32'(sdwr_bytes), 32'd8);

        // 6: push while full with a pop, then reset mid-burst
        check("t6_head", 32'(sdram_wr_data), 32'h6000);
        sdram_wr_ack = 1'b1;
        wr_push = 1'b1;
        wr_din  = 16'h7777;
        tick();
        wr_push = 1'b0;
        check("t6_level_pp", 32'(wr_level), 32'd32);
        check("t6_req_drop", 32'(sdram_wr_req), 32'd0);
        ack_words(16'h6001, 2);
        check("t6_level", 32'(wr_level), 32'd30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_req", 32'(sdram_wr_req), 32'd0);
        check("t6_rst_level", 32'(wr_level), 32'd0);
        check("t6_rst_ready", 32'(rd_ready), 32'd1);
        check("t6_rst_full", 32'(wr_full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
